// File: rtl/accel_spi3w_responder_if.sv
// SPI pin bundle and parallel sample input of the accelerometer responder.
// The master modport is the initiator/sample-source side; slave is the responder.
interface accel_spi3w_responder_if;
  localparam int unsigned SAMP_W = 16;

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_sdat_i;
  logic              spi_sdat_o;
  logic              spi_sdat_oe;
  logic              spi_int;
  logic              sample_valid;
  logic [SAMP_W-1:0] sample_x;
  logic [SAMP_W-1:0] sample_y;
  logic [SAMP_W-1:0] sample_z;

  modport master (
    output spi_sclk, spi_cs_n, spi_sdat_i, sample_valid, sample_x, sample_y, sample_z,
    input  spi_sdat_o, spi_sdat_oe, spi_int
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_sdat_i, sample_valid, sample_x, sample_y, sample_z,
    output spi_sdat_o, spi_sdat_oe, spi_int
  );
endinterface

// File: rtl/accel_spi3w_responder.sv
// Accelerometer-side 3-wire SPI responder with a reduced ADXL345-style register file.
// Optional OVERRUN flag in INT_SOURCE bit0 is enabled by defining ACCEL_OVERRUN_EN.
module accel_spi3w_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_VAL   = 8'hE5
) (
  input logic                    clk_clk,
  input logic                    reset_reset_n,
  accel_spi3w_responder_if.slave bus
);
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned SAMP_W      = 16;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned MEASURE_BIT = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RD, ST_WR} state_e;

  // Pin synchronizers and edge detection on the synchronized copies
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdat_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, sdat_s;
  logic                   sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sdat_s      = sdat_sync_q[SYNC_STAGES-1];
  assign sclk_rise_c = sclk_s & ~sclk_prev_q;
  assign sclk_fall_c = ~sclk_s & sclk_prev_q;
  assign cs_rise_c   = cs_s & ~cs_prev_q;
  assign cs_fall_c   = ~cs_s & cs_prev_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      sdat_sync_q <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], bus.spi_sdat_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic                mb_q, mb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sdat_o_q, sdat_o_d, oe_q, oe_d, int_q, int_d;
  logic [BYTE_W-1:0]   bw_q, bw_d, pwr_q, pwr_d, ien_q, ien_d, fmt_q, fmt_d;
  logic [SAMP_W-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic [SAMP_W-1:0]   sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic                pend_q, pend_d, dr_q, dr_d;
  logic                rd_done_c, wr_en_c, apply_c, ovr_c;
  logic [BYTE_W-1:0]   rx_byte_c, rd_byte_c, int_src_c;
  logic [ADDR_W-1:0]   next_addr_c;

  assign rx_byte_c   = {shift_q[BYTE_W-2:0], sdat_s};
  assign next_addr_c = mb_q ? ADDR_W'(addr_q + ADDR_W'(1)) : addr_q;
  assign int_src_c   = {dr_q, 6'b0, ovr_c};

  always_comb begin
    rd_byte_c = '0;
    case (addr_q)
      6'h00:   rd_byte_c = DEVID_VAL;
      6'h2C:   rd_byte_c = bw_q;
      6'h2D:   rd_byte_c = pwr_q;
      6'h2E:   rd_byte_c = ien_q;
      6'h30:   rd_byte_c = int_src_c;
      6'h31:   rd_byte_c = fmt_q;
      6'h32:   rd_byte_c = x_q[7:0];
      6'h33:   rd_byte_c = x_q[15:8];
      6'h34:   rd_byte_c = y_q[7:0];
      6'h35:   rd_byte_c = y_q[15:8];
      6'h36:   rd_byte_c = z_q[7:0];
      6'h37:   rd_byte_c = z_q[15:8];
      default: rd_byte_c = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    mb_d      = mb_q;
    addr_d    = addr_q;
    sdat_o_d  = sdat_o_q;
    oe_d      = oe_q;
    bw_d      = bw_q;
    pwr_d     = pwr_q;
    ien_d     = ien_q;
    fmt_d     = fmt_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    sz_d      = sz_q;
    pend_d    = pend_q;
    dr_d      = dr_q;
    int_d     = |(int_src_c & ien_q);
    rd_done_c = 1'b0;
    wr_en_c   = 1'b0;
    apply_c   = 1'b0;

    // Deselect aborts any frame; a partial byte never reaches the register file
    if (cs_rise_c) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      sdat_o_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_c) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise_c) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = CNT_W'(bit_cnt_q + CNT_W'(1));
            if (bit_cnt_q == CNT_W'(7)) begin
              mb_d    = rx_byte_c[6];
              addr_d  = rx_byte_c[ADDR_W-1:0];
              state_d = rx_byte_c[7] ? ST_RD : ST_WR;
            end
          end
        end
        ST_RD: begin
          if (sclk_fall_c) begin
            if (bit_cnt_q == '0) begin
              oe_d     = 1'b1;
              sdat_o_d = rd_byte_c[7];
              shift_d  = {rd_byte_c[BYTE_W-2:0], 1'b0};
            end else begin
              sdat_o_d = shift_q[7];
              shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
            end
          end
          if (sclk_rise_c) begin
            bit_cnt_d = CNT_W'(bit_cnt_q + CNT_W'(1));
            if (bit_cnt_q == CNT_W'(7)) begin
              rd_done_c = 1'b1;
              addr_d    = next_addr_c;
            end
          end
        end
        ST_WR: begin
          if (sclk_rise_c) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = CNT_W'(bit_cnt_q + CNT_W'(1));
            if (bit_cnt_q == CNT_W'(7)) begin
              wr_en_c = 1'b1;
              addr_d  = next_addr_c;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (wr_en_c) begin
      case (addr_q)
        6'h2C:   bw_d  = rx_byte_c;
        6'h2D:   pwr_d = rx_byte_c;
        6'h2E:   ien_d = rx_byte_c;
        6'h31:   fmt_d = rx_byte_c;
        default: ;
      endcase
    end

    if (rd_done_c && (addr_q >= 6'h32) && (addr_q <= 6'h37)) dr_d = 1'b0;

    // Samples arriving mid-frame wait in the shadow until deselect
    if (bus.sample_valid && pwr_q[MEASURE_BIT]) begin
      if (cs_s) begin
        apply_c = 1'b1;
        x_d = bus.sample_x;
        y_d = bus.sample_y;
        z_d = bus.sample_z;
      end else begin
        sx_d   = bus.sample_x;
        sy_d   = bus.sample_y;
        sz_d   = bus.sample_z;
        pend_d = 1'b1;
      end
    end else if (cs_rise_c && pend_q) begin
      apply_c = 1'b1;
      x_d = sx_q;
      y_d = sy_q;
      z_d = sz_q;
    end
    if (cs_rise_c) pend_d = 1'b0;
    if (apply_c) dr_d = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      mb_q      <= 1'b0;
      addr_q    <= '0;
      sdat_o_q  <= 1'b0;
      oe_q      <= 1'b0;
      int_q     <= 1'b0;
      bw_q      <= 8'h0A;
      pwr_q     <= '0;
      ien_q     <= '0;
      fmt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      sz_q      <= '0;
      pend_q    <= 1'b0;
      dr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      mb_q      <= mb_d;
      addr_q    <= addr_d;
      sdat_o_q  <= sdat_o_d;
      oe_q      <= oe_d;
      int_q     <= int_d;
      bw_q      <= bw_d;
      pwr_q     <= pwr_d;
      ien_q     <= ien_d;
      fmt_q     <= fmt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      sz_q      <= sz_d;
      pend_q    <= pend_d;
      dr_q      <= dr_d;
    end
  end

`ifdef ACCEL_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Set wins over the clear from a completed INT_SOURCE read
  always_comb begin
    ovr_d = ovr_q;
    if (rd_done_c && (addr_q == 6'h30)) ovr_d = 1'b0;
    if (apply_c && dr_q) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) ovr_q <= 1'b0;
    else                ovr_q <= ovr_d;
  end

  assign ovr_c = ovr_q;
`else
  assign ovr_c = 1'b0;
`endif

  assign bus.spi_sdat_o  = sdat_o_q;
  assign bus.spi_sdat_oe = oe_q;
  assign bus.spi_int     = int_q;
endmodule

// File: tb/tb_accel_spi3w_responder.sv
// Self-checking bench for accel_spi3w_responder: directed table, corner sequences,
// and randomized traffic against a register-level reference model.
module tb_accel_spi3w_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  accel_spi3w_responder_if ifc();

  accel_spi3w_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (ifc.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  m_bw = 8'h0A, m_pwr = 8'h00, m_ien = 8'h00, m_fmt = 8'h00;
  logic [15:0] mx = '0, my = '0, mz = '0, px = '0, py = '0, pz = '0;
  bit          m_dr = 0, m_ovr = 0, m_pend = 0, m_cs_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [5:0] a);
    case (a)
      6'h00:   return 8'hE5;
      6'h2C:   return m_bw;
      6'h2D:   return m_pwr;
      6'h2E:   return m_ien;
      6'h30:   return {m_dr, 6'b0, m_ovr};
      6'h31:   return m_fmt;
      6'h32:   return mx[7:0];
      6'h33:   return mx[15:8];
      6'h34:   return my[7:0];
      6'h35:   return my[15:8];
      6'h36:   return mz[7:0];
      6'h37:   return mz[15:8];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_int();
    return |({m_dr, 6'b0, m_ovr} & m_ien);
  endfunction

  task automatic m_wr(input logic [5:0] a, input logic [7:0] d);
    case (a)
      6'h2C: m_bw  = d;
      6'h2D: m_pwr = d;
      6'h2E: m_ien = d;
      6'h31: m_fmt = d;
      default: ;
    endcase
  endtask

  task automatic m_apply(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
`ifdef ACCEL_OVERRUN_EN
    if (m_dr) m_ovr = 1;
`endif
    mx = x; my = y; mz = z;
    m_dr = 1;
  endtask

  task automatic m_rd_done(input logic [5:0] a);
    if (a >= 6'h32 && a <= 6'h37) m_dr = 0;
    if (a == 6'h30) m_ovr = 0;
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    ifc.sample_x = x; ifc.sample_y = y; ifc.sample_z = z;
    ifc.sample_valid = 1'b1;
    @(negedge clk);
    ifc.sample_valid = 1'b0;
    if (m_pwr[3]) begin
      if (m_cs_low) begin px = x; py = y; pz = z; m_pend = 1; end
      else m_apply(x, y, z);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_begin();
    ifc.spi_cs_n = 1'b0;
    m_cs_low = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    ifc.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("oe_after_cs", ifc.spi_sdat_oe, 1'b0);
    m_cs_low = 0;
    if (m_pend) m_apply(px, py, pz);
    m_pend = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input bit is_rd, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - n; i--) begin
      ifc.spi_sclk   = 1'b0;
      ifc.spi_sdat_i = is_rd ? 1'b0 : tx[i];
      repeat (8) @(negedge clk);
      if (is_rd) begin
        if (i == 7) check("oe_data", ifc.spi_sdat_oe, 1'b1);
        rx[i] = ifc.spi_sdat_o;
      end else if (i == 0) begin
        check("oe_not_rd", ifc.spi_sdat_oe, 1'b0);
      end
      ifc.spi_sclk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, input bit is_rd, output logic [7:0] rx);
    xfer_bits(tx, is_rd, 8, rx);
  endtask

  task automatic wr_txn(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] rx;
    cs_begin();
    xfer_byte({2'b00, a}, 0, rx);
    xfer_byte(d, 0, rx);
    m_wr(a, d);
    cs_end();
  endtask

  task automatic rd1(input logic [5:0] a, output logic [7:0] rx);
    logic [7:0] dummy;
    cs_begin();
    xfer_byte({2'b10, a}, 0, dummy);
    xfer_byte(8'h00, 1, rx);
    m_rd_done(a);
    cs_end();
  endtask

  task automatic rd_txn(input logic [5:0] a, input bit mb, input int n, input int pulse_at,
                        input string name);
    logic [7:0] rx;
    logic [5:0] cur;
    cur = a;
    cs_begin();
    xfer_byte({1'b1, mb, a}, 0, rx);
    for (int k = 0; k < n; k++) begin
      if (k == pulse_at) pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
      xfer_byte(8'h00, 1, rx);
      check(name, rx, m_rd(cur));
      m_rd_done(cur);
      if (mb) cur = 6'(cur + 6'd1);
    end
    cs_end();
  endtask

  typedef struct {
    bit         rd;
    logic [5:0] addr;
    logic [7:0] data;
  } vec_t;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t       tbl[14];
    logic [7:0] rx;
    logic [7:0] exp_mb[6];
    logic [7:0] exp_src;
    logic [5:0] ra[12];

    tbl[0]  = '{1'b1, 6'h00, 8'hE5};
    tbl[1]  = '{1'b1, 6'h2C, 8'h0A};
    tbl[2]  = '{1'b1, 6'h2D, 8'h00};
    tbl[3]  = '{1'b1, 6'h2E, 8'h00};
    tbl[4]  = '{1'b1, 6'h30, 8'h00};
    tbl[5]  = '{1'b0, 6'h2D, 8'h08};
    tbl[6]  = '{1'b1, 6'h2D, 8'h08};
    tbl[7]  = '{1'b0, 6'h00, 8'h12};
    tbl[8]  = '{1'b1, 6'h00, 8'hE5};
    tbl[9]  = '{1'b0, 6'h31, 8'h0B};
    tbl[10] = '{1'b1, 6'h31, 8'h0B};
    tbl[11] = '{1'b0, 6'h10, 8'h55};
    tbl[12] = '{1'b1, 6'h10, 8'h00};
    tbl[13] = '{1'b1, 6'h32, 8'h00};

    ifc.spi_sclk = 1'b1; ifc.spi_cs_n = 1'b1; ifc.spi_sdat_i = 1'b0;
    ifc.sample_valid = 1'b0; ifc.sample_x = '0; ifc.sample_y = '0; ifc.sample_z = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_oe", ifc.spi_sdat_oe, 1'b0);
    check("rst_sdat", ifc.spi_sdat_o, 1'b0);
    check("rst_int", ifc.spi_int, 1'b0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rd) begin
        rd1(tbl[i].addr, rx);
        check($sformatf("tbl%0d_rd_%0h", i, tbl[i].addr), rx, tbl[i].data);
      end else begin
        wr_txn(tbl[i].addr, tbl[i].data);
      end
    end

    // Multi-byte data read and interrupt clear
    wr_txn(6'h2E, 8'h80);
    pulse_sample(16'h1234, 16'hFFFE, 16'h0100);
    check("mb_int_set", ifc.spi_int, 1'b1);
    exp_mb = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};
    cs_begin();
    xfer_byte(8'hF2, 0, rx);
    for (int k = 0; k < 6; k++) begin
      xfer_byte(8'h00, 1, rx);
      check($sformatf("mb_byte%0d", k), rx, exp_mb[k]);
      m_rd_done(6'(6'h32 + k));
      if (k == 0) check("mb_int_clr", ifc.spi_int, 1'b0);
    end
    cs_end();

    // Deferred sample load: mid-frame samples stay hidden, latest one wins
    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    cs_begin();
    xfer_byte(8'hF2, 0, rx);
    pulse_sample(16'hAAAA, 16'hBBBB, 16'hCCCC);
    xfer_byte(8'h00, 1, rx);
    check("defer_old0", rx, 8'h11);
    m_rd_done(6'h32);
    pulse_sample(16'h5555, 16'h6666, 16'h7777);
    xfer_byte(8'h00, 1, rx);
    check("defer_old1", rx, 8'h11);
    m_rd_done(6'h33);
    cs_end();
    exp_mb = '{8'h55, 8'h55, 8'h66, 8'h66, 8'h77, 8'h77};
    cs_begin();
    xfer_byte(8'hF2, 0, rx);
    for (int k = 0; k < 6; k++) begin
      xfer_byte(8'h00, 1, rx);
      check($sformatf("defer_new%0d", k), rx, exp_mb[k]);
      m_rd_done(6'(6'h32 + k));
    end
    cs_end();

    // Aborted write leaves the register untouched
    cs_begin();
    xfer_byte(8'h2E, 0, rx);
    xfer_bits(8'h3C, 0, 4, rx);
    cs_end();
    rd1(6'h2E, rx);
    check("abort_ien", rx, 8'h80);

    // Multi-byte address wrap 0x3F -> 0x00
    cs_begin();
    xfer_byte(8'hFF, 0, rx);
    xfer_byte(8'h00, 1, rx);
    check("wrap_3f", rx, 8'h00);
    xfer_byte(8'h00, 1, rx);
    check("wrap_00", rx, 8'hE5);
    cs_end();

    // Back-to-back samples without a data read
`ifdef ACCEL_OVERRUN_EN
    exp_src = 8'h81;
`else
    exp_src = 8'h80;
`endif
    rd_txn(6'h32, 0, 1, -1, "ovr_pre");
    rd_txn(6'h30, 0, 1, -1, "ovr_pre_src");
    pulse_sample(16'h0001, 16'h0002, 16'h0003);
    pulse_sample(16'h0004, 16'h0005, 16'h0006);
    wr_txn(6'h2E, 8'h01);
    repeat (4) @(negedge clk);
    check("ovr_int", ifc.spi_int, exp_src[0]);
    rd1(6'h30, rx);
    check("ovr_src1", rx, exp_src);
    rd1(6'h30, rx);
    check("ovr_src2", rx, 8'h80);
    check("ovr_int_clr", ifc.spi_int, 1'b0);

    // Randomized traffic against the model
    ra = '{6'h00, 6'h2C, 6'h2D, 6'h2E, 6'h30, 6'h31, 6'h32, 6'h33, 6'h35, 6'h37, 6'h3F, 6'h2F};
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
        1: begin
          case ($urandom_range(0, 3))
            0: wr_txn(6'h2C, 8'($urandom));
            1: wr_txn(6'h2D, 8'($urandom) | 8'h08);
            2: wr_txn(6'h2E, 8'($urandom));
            default: wr_txn(6'h31, 8'($urandom));
          endcase
        end
        2: rd_txn(ra[$urandom_range(0, 11)], 1'($urandom), $urandom_range(1, 3), -1, "rand_rd");
        default: rd_txn(ra[$urandom_range(0, 11)], 1'($urandom), 2, 1, "rand_rd_defer");
      endcase
      repeat (4) @(negedge clk);
      check("rand_int", ifc.spi_int, m_int());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
